// File: rtl/register_file_24_if.sv
// Register-file bus: write port, two operand read ports, debug inspection port and write counter.
// The master is the datapath/writeback side; the slave is the register file.
interface register_file_24_if #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 4
) ();
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [ADDR_W-1:0] DbgAddr;
  logic [WIDTH-1:0]  DbgData;
  logic [15:0]       WriteCount;

  modport master (
    output RegWrite, WriteAddr, WriteData, ReadAddr1, ReadAddr2, DbgAddr,
    input  ReadData1, ReadData2, DbgData, WriteCount
  );

  modport slave (
    input  RegWrite, WriteAddr, WriteData, ReadAddr1, ReadAddr2, DbgAddr,
    output ReadData1, ReadData2, DbgData, WriteCount
  );
endinterface

// File: rtl/register_file_24.sv
// 16 x 24-bit register file with r0 hardwired to zero, two combinational read ports,
// optional same-cycle write-to-read bypass, and a saturating committed-write counter.
module register_file_24 #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  register_file_24_if.slave   bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [15:0]      count_q, count_d;
  logic             wr_en;
  logic             byp1, byp2;

  // A write only commits to a real register; address 0 is a sink.
  assign wr_en = bus.RegWrite && (bus.WriteAddr != '0);

  // NOTE: the array is reset because the spec requires every register to read 0 after
  // reset; this rules out inferring block RAM, which is acceptable at 16 entries.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wr_en) begin
        regs_q[bus.WriteAddr] <= bus.WriteData;
      end
      count_q <= count_d;
    end
  end

  // NOTE: default assigned first so the combinational block cannot infer a latch.
  always_comb begin
    count_d = count_q;
    if (wr_en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Bypass is gated with Reset_n so outputs stay 0 while reset is held.
  assign byp1 = BYPASS && Reset_n && wr_en && (bus.ReadAddr1 == bus.WriteAddr);
  assign byp2 = BYPASS && Reset_n && wr_en && (bus.ReadAddr2 == bus.WriteAddr);

  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    if (bus.ReadAddr1 != '0) begin
      bus.ReadData1 = byp1 ? bus.WriteData : regs_q[bus.ReadAddr1];
    end
    if (bus.ReadAddr2 != '0) begin
      bus.ReadData2 = byp2 ? bus.WriteData : regs_q[bus.ReadAddr2];
    end
  end

  // Debug port shows only committed state; r0 is never written so it reads 0.
  assign bus.DbgData    = regs_q[bus.DbgAddr];
  assign bus.WriteCount = count_q;

endmodule

// File: tb/tb_register_file_24.sv
// Directed self-checking bench: one BYPASS=1 and one BYPASS=0 instance share the same stimulus.
module tb_register_file_24;

  logic        Clock;
  logic        Reset_n;
  logic        reg_write;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [3:0]  dbg_addr;

  int total_checks = 0;
  int fail_checks  = 0;

  register_file_24_if #(.WIDTH(24), .ADDR_W(4)) bus_a ();
  register_file_24_if #(.WIDTH(24), .ADDR_W(4)) bus_b ();

  assign bus_a.RegWrite  = reg_write;
  assign bus_a.WriteAddr = wr_addr;
  assign bus_a.WriteData = wr_data;
  assign bus_a.ReadAddr1 = rd_addr1;
  assign bus_a.ReadAddr2 = rd_addr2;
  assign bus_a.DbgAddr   = dbg_addr;
  assign bus_b.RegWrite  = reg_write;
  assign bus_b.WriteAddr = wr_addr;
  assign bus_b.WriteData = wr_data;
  assign bus_b.ReadAddr1 = rd_addr1;
  assign bus_b.ReadAddr2 = rd_addr2;
  assign bus_b.DbgAddr   = dbg_addr;

  register_file_24 #(.WIDTH(24), .ADDR_W(4), .BYPASS(1'b1)) dut_a (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus_a.slave)
  );

  register_file_24 #(.WIDTH(24), .ADDR_W(4), .BYPASS(1'b0)) dut_b (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus_b.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      fail_checks++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a write, commit it on the next rising edge, then drop RegWrite.
  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    reg_write = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    @(posedge Clock);
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    Reset_n   = 1'b0;
    reg_write = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr1  = 4'd3;
    rd_addr2  = 4'd7;
    dbg_addr  = 4'd9;
    #2;
    check("por_rd1", {8'h0, bus_a.ReadData1}, 32'h0);
    check("por_cnt", {16'h0, bus_a.WriteCount}, 32'h0);
    #10 Reset_n = 1'b1;  // released mid-cycle
    @(posedge Clock);
    #1;

    // 1. Fill r1..r15, then reset mid-cycle with a write pending on r3.
    for (int i = 1; i < 16; i++) wr(4'(i), 24'hA5A5A5);
    check("fill_dbg9", {8'h0, bus_a.DbgData}, 32'h00A5A5A5);
    check("fill_cnt", {16'h0, bus_a.WriteCount}, 32'd15);
    reg_write = 1'b1;
    wr_addr   = 4'd3;
    wr_data   = 24'h777777;
    #1;
    check("pre_rst_byp", {8'h0, bus_a.ReadData1}, 32'h00777777);
    #1 Reset_n = 1'b0;
    #1;
    check("rst_rd1_a", {8'h0, bus_a.ReadData1}, 32'h0);
    check("rst_rd2_a", {8'h0, bus_a.ReadData2}, 32'h0);
    check("rst_dbg_a", {8'h0, bus_a.DbgData}, 32'h0);
    check("rst_cnt_a", {16'h0, bus_a.WriteCount}, 32'h0);
    check("rst_rd1_b", {8'h0, bus_b.ReadData1}, 32'h0);
    @(posedge Clock);
    #3;
    reg_write = 1'b0;
    Reset_n   = 1'b1;
    #1;
    dbg_addr = 4'd3;
    #1;
    check("rst_wr_drop", {8'h0, bus_a.DbgData}, 32'h0);
    check("rst_cnt_hold", {16'h0, bus_a.WriteCount}, 32'h0);
    @(posedge Clock);
    #1;

    // 2. Basic write/read.
    wr(4'd3, 24'h123456);
    wr(4'd7, 24'hFFFFFF);
    rd_addr1 = 4'd3;
    rd_addr2 = 4'd7;
    #1;
    check("basic_rd1", {8'h0, bus_a.ReadData1}, 32'h00123456);
    check("basic_rd2", {8'h0, bus_a.ReadData2}, 32'h00FFFFFF);
    check("basic_rd1_b", {8'h0, bus_b.ReadData1}, 32'h00123456);
    check("basic_cnt", {16'h0, bus_a.WriteCount}, 32'd2);

    // 3. Writes to r0 are ignored and never bypassed.
    reg_write = 1'b1;
    wr_addr   = 4'd0;
    wr_data   = 24'hDEADBE;
    rd_addr1  = 4'd0;
    rd_addr2  = 4'd0;
    #1;
    check("r0_same_a", {8'h0, bus_a.ReadData1}, 32'h0);
    check("r0_same_a2", {8'h0, bus_a.ReadData2}, 32'h0);
    @(posedge Clock);
    #1;
    reg_write = 1'b0;
    dbg_addr  = 4'd0;
    #1;
    check("r0_next_a", {8'h0, bus_a.ReadData1}, 32'h0);
    check("r0_dbg", {8'h0, bus_a.DbgData}, 32'h0);
    check("r0_cnt", {16'h0, bus_a.WriteCount}, 32'd2);

    // 4. Bypass versus stored path on r5.
    wr(4'd5, 24'h000011);
    reg_write = 1'b1;
    wr_addr   = 4'd5;
    wr_data   = 24'h000022;
    rd_addr1  = 4'd5;
    rd_addr2  = 4'd5;
    dbg_addr  = 4'd5;
    #1;
    check("byp_rd1_a", {8'h0, bus_a.ReadData1}, 32'h00000022);
    check("byp_rd2_a", {8'h0, bus_a.ReadData2}, 32'h00000022);
    check("byp_dbg_a", {8'h0, bus_a.DbgData}, 32'h00000011);
    check("nbyp_rd1_b", {8'h0, bus_b.ReadData1}, 32'h00000011);
    check("nbyp_rd2_b", {8'h0, bus_b.ReadData2}, 32'h00000011);
    @(posedge Clock);
    #1;
    reg_write = 1'b0;
    #1;
    check("post_rd1_a", {8'h0, bus_a.ReadData1}, 32'h00000022);
    check("post_rd1_b", {8'h0, bus_b.ReadData1}, 32'h00000022);
    check("post_rd2_b", {8'h0, bus_b.ReadData2}, 32'h00000022);
    check("byp_cnt", {16'h0, bus_a.WriteCount}, 32'd4);

    // With RegWrite low, address and data must not disturb state.
    wr_addr = 4'd7;
    wr_data = 24'h0BAD00;
    rd_addr1 = 4'd7;
    @(posedge Clock);
    #1;
    check("idle_r7", {8'h0, bus_a.ReadData1}, 32'h00FFFFFF);
    check("idle_cnt", {16'h0, bus_a.WriteCount}, 32'd4);

    // 5. Reset held across an edge with a write to r4 pending.
    reg_write = 1'b1;
    wr_addr   = 4'd4;
    wr_data   = 24'h0000AB;
    rd_addr1  = 4'd4;
    dbg_addr  = 4'd4;
    #3 Reset_n = 1'b0;
    @(posedge Clock);
    #3 Reset_n = 1'b1;
    #1;
    check("rvw_dbg", {8'h0, bus_a.DbgData}, 32'h0);
    check("rvw_cnt", {16'h0, bus_a.WriteCount}, 32'h0);
    check("rvw_byp_a", {8'h0, bus_a.ReadData1}, 32'h000000AB);
    check("rvw_nbyp_b", {8'h0, bus_b.ReadData1}, 32'h0);
    @(posedge Clock);
    #1;
    reg_write = 1'b0;
    check("rvw_commit", {8'h0, bus_a.DbgData}, 32'h000000AB);
    check("rvw_cnt1", {16'h0, bus_a.WriteCount}, 32'd1);

    // 6. Saturation: count starts at 1, 65540 writes to r1 follow.
    dbg_addr = 4'd1;
    for (int i = 0; i < 65533; i++) wr(4'd1, 24'(i));
    check("sat_fffe", {16'h0, bus_a.WriteCount}, 32'h0000FFFE);
    wr(4'd1, 24'(65533));
    check("sat_ffff", {16'h0, bus_a.WriteCount}, 32'h0000FFFF);
    for (int i = 65534; i < 65540; i++) wr(4'd1, 24'(i));
    check("sat_hold_a", {16'h0, bus_a.WriteCount}, 32'h0000FFFF);
    check("sat_hold_b", {16'h0, bus_b.WriteCount}, 32'h0000FFFF);
    check("sat_r1", {8'h0, bus_a.DbgData}, 32'h00010003);

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/register_file_24.md
Name: register_file_24

Overview:
- 24-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the 24-bit ALU built from the 1-bit ALU slices; its two read ports supply the ALU A/B operands.
- Writeback stage writes the ALU Result, or load data, back into it on the clock edge.
- Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass is provided.

Parameters:
- WIDTH, 24, data width of each register and of all data ports.
- ADDR_W, 4, address width; register count = 2**ADDR_W (16).
- BYPASS, 1, 1 = a read of the address being written returns WriteData in the same cycle; 0 = returns the stored (old) value.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- RegWrite  in  1  write enable, sampled on rising Clock.
- WriteAddr  in  ADDR_W  destination register.
- WriteData  in  WIDTH  data to write.
- ReadAddr1  in  ADDR_W  source register for operand A.
- ReadAddr2  in  ADDR_W  source register for operand B.
- ReadData1  out  WIDTH  operand A to ALU, combinational.
- ReadData2  out  WIDTH  operand B to ALU, combinational.
- DbgAddr  in  ADDR_W  debug/testbench inspection address.
- DbgData  out  WIDTH  contents of register DbgAddr, combinational, never bypassed.
- WriteCount  out  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Storage: 2**ADDR_W registers of WIDTH bits, one clock domain (Clock).
- Reset:
  - Reset_n low asynchronously clears every register and WriteCount to 0.
  - All outputs read 0 while reset is held.
  - Any write presented while Reset_n is low is discarded.
  - First write is accepted on the first rising Clock with Reset_n high.
- Write:
  - On rising Clock, if RegWrite=1 and WriteAddr!=0, register[WriteAddr] <= WriteData.
  - Takes effect one edge later: visible on the stored path from the following cycle.
- Register 0:
  - Writes to address 0 are ignored and do not increment WriteCount.
  - Reads of address 0 always return 0 on every port, even with BYPASS=1 and a concurrent write to 0.
- Read:
  - ReadData1/2 are purely combinational from the address and the storage array (zero read latency).
  - Suitable for the single-cycle datapath.
- Bypass (BYPASS=1):
  - If RegWrite=1, WriteAddr!=0 and ReadAddrN==WriteAddr, then ReadDataN = WriteData in the same cycle.
  - Both read ports bypass independently. Identical read addresses return identical data.
- No bypass (BYPASS=0): ReadDataN returns the pre-edge stored value until the write commits.
- DbgData: always the stored value, unaffected by BYPASS and by pending writes.
- WriteCount:
  - Increments by 1 on each committed write (RegWrite=1, WriteAddr!=0, Reset_n high).
  - Holds at 16'hFFFF once reached; no wrap-around.
- X-safety: with RegWrite=0, WriteAddr and WriteData are don't-care and must not alter state.
- Simultaneous events:
  - Reset assertion coincident with a Clock edge: reset wins, and the register stays 0.
  - Write and read of the same register in one cycle: BYPASS governs the same-cycle read, and the stored value updates at the edge.

Test Plan:
1. Reset: fill r1..r15 with 24'hA5A5A5, pulse Reset_n low mid-cycle (not on an edge) -> all ReadData/DbgData = 0 immediately, WriteCount = 0.
2. Basic write/read: write r3=24'h123456, then r7=24'hFFFFFF; next cycle read (3,7) -> ReadData1=24'h123456, ReadData2=24'hFFFFFF; WriteCount=2.
3. r0: RegWrite=1, WriteAddr=0, WriteData=24'hDEADBE, ReadAddr1=0 -> ReadData1=0 in the same and the next cycle; WriteCount unchanged.
4. Bypass: r5 holds 24'h000011; same cycle write r5=24'h000022 with ReadAddr1=ReadAddr2=5.
   - BYPASS=1 -> both reads = 24'h000022 before the edge, DbgData(5)=24'h000011.
   - BYPASS=0 -> both = 24'h000011 until the edge, then 24'h000022.
5. Reset vs write: Reset_n low across a Clock edge with RegWrite=1, WriteAddr=4, WriteData=24'h0000AB -> r4=0 after reset release; first post-release write of 24'h0000AB to r4 commits.
6. Saturation: 65540 consecutive writes to r1 -> WriteCount stops at 16'hFFFF; r1 holds the last data written.
